// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges pipeline results with buffered long-latency results onto the regfile write port.
// Optional WB_BYPASS_EN: an lu result arriving at an idle, empty stage is written without being buffered.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        we,
  output logic [4:0]  writeaddr,
  output logic [31:0] writedata,
  output logic [31:0] busy,
  output logic        stall_req
);

  localparam int IW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(STARVE_MAX);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_HI   = CW'(DEPTH - 1);
  localparam logic [AGW-1:0] AGE_HI   = AGW'(STARVE_MAX - 1);

  // lu handshake: a result transfers on a posedge where lu_valid && lu_ready;
  // the producer holds lu_valid/lu_rd/lu_data stable while lu_ready is low.

  logic [CW-1:0]  count_q, count_d;
  logic [AGW-1:0] age_q, age_d;
  logic [4:0]     rd_q   [DEPTH];
  logic [4:0]     rd_d   [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [31:0]    data_d [DEPTH];
  logic           we_q, we_d;
  logic [4:0]     wa_q, wa_d;
  logic [31:0]    wd_q, wd_d;
  logic           stall_q, stall_d;

  logic             pipe_issue, lu_xfer, fifo_empty, pop, push, bypass;
  logic [DEPTH-1:0] squash;
  logic [CW-1:0]    n;

  assign pipe_issue = pipe_we && (pipe_rd != 5'd0);
  assign lu_xfer    = lu_valid && lu_ready;
  assign fifo_empty = (count_q == '0);
  assign pop        = !pipe_issue && !fifo_empty;
  assign lu_ready   = (count_q != CNT_FULL);

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !pipe_issue && lu_xfer && (lu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // A result colliding with the concurrent pipe write is already stale.
  assign push = lu_xfer && (lu_rd != 5'd0) && !(pipe_issue && (lu_rd == pipe_rd)) && !bypass;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = pipe_issue && (i < int'(count_q)) && (rd_q[i] == pipe_rd);
    end
  end

  // The queue is kept compacted with the head in slot 0, so squashed entries
  // vanish in the cycle they are hit and never cost an output slot.
  always_comb begin
    n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count_q)) && !squash[i] && !(pop && (i == 0))) begin
        rd_d[n[IW-1:0]]   = rd_q[i];
        data_d[n[IW-1:0]] = data_q[i];
        n = n + CW'(1);
      end
    end
    if (push) begin
      rd_d[n[IW-1:0]]   = lu_rd;
      data_d[n[IW-1:0]] = lu_data;
      n = n + CW'(1);
    end
    count_d = n;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_q)) busy[rd_q[i]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

  always_comb begin
    if (fifo_empty || pop || squash[0]) age_d = '0;
    else if (age_q != AGE_HI)           age_d = age_q + AGW'(1);
    else                                age_d = age_q;
    stall_d = (count_d >= CNT_HI) || (age_d >= AGE_HI);
  end

  always_comb begin
    we_d = pipe_issue || pop || bypass;
    wa_d = wa_q;
    wd_d = wd_q;
    if (pipe_issue) begin
      wa_d = pipe_rd;
      wd_d = pipe_data;
    end else if (pop) begin
      wa_d = rd_q[0];
      wd_d = data_q[0];
    end else if (bypass) begin
      wa_d = lu_rd;
      wd_d = lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      age_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      stall_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      age_q   <= age_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      stall_q <= stall_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign we        = we_q;
  assign writeaddr = wa_q;
  assign writedata = wd_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (default build): vector table plus multi-cycle sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        we;
  logic [4:0]  writeaddr;
  logic [31:0] writedata;
  logic [31:0] busy;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .we(we), .writeaddr(writeaddr), .writedata(writedata),
    .busy(busy), .stall_req(stall_req)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic        e_rdy;
    logic        e_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    pipe_we   = pwe;
    pipe_rd   = prd;
    pipe_data = pd;
    lu_valid  = lv;
    lu_rd     = lr;
    lu_data   = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int li;
    logic xfer;
    logic [36:0] e;

    vecs[0]  = '{1, 5'd5,  32'h11, 1, 5'd6,  32'h22,       1, 5'd5,  32'h11, 32'h40,   1, 0};
    vecs[1]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        1, 5'd6,  32'h22, 32'h0,    1, 0};
    vecs[2]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  32'h0,    1, 0};
    vecs[3]  = '{0, 5'd0,  32'h0,  1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,  32'h0,    1, 0};
    vecs[4]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  32'h0,    1, 0};
    vecs[5]  = '{1, 5'd8,  32'h1,  1, 5'd7,  32'hAA,       1, 5'd8,  32'h1,  32'h80,   1, 0};
    vecs[6]  = '{1, 5'd9,  32'h2,  0, 5'd0,  32'h0,        1, 5'd9,  32'h2,  32'h80,   1, 0};
    vecs[7]  = '{1, 5'd7,  32'hBB, 0, 5'd0,  32'h0,        1, 5'd7,  32'hBB, 32'h0,    1, 0};
    vecs[8]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  32'h0,    1, 0};
    vecs[9]  = '{1, 5'd4,  32'h44, 1, 5'd4,  32'h55,       1, 5'd4,  32'h44, 32'h0,    1, 0};
    vecs[10] = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  32'h0,    1, 0};
    vecs[11] = '{1, 5'd0,  32'h99, 1, 5'd12, 32'hC,        0, 5'd0,  32'h0,  32'h1000, 1, 0};
    vecs[12] = '{1, 5'd0,  32'h98, 0, 5'd0,  32'h0,        1, 5'd12, 32'hC,  32'h0,    1, 0};
    vecs[13] = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  32'h0,    1, 0};

    // reset state
    idle();
    #12;
    check("rst_we", 32'(we), 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_ready", 32'(lu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // table: priority, x0, squash, same-cycle collision, pipe x0 slot
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].pwe, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      tick();
      check($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i), 32'(writeaddr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d_data", i), writedata, vecs[i].e_data);
      end
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_stall", i), 32'(stall_req), 32'(vecs[i].e_stall));
    end

    // full / backpressure: pipe busy 6 cycles, 5 lu results offered back-to-back
    li = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'(20 + c), 32'(32'h100 + c), li < 5, 5'(10 + li), 32'(32'h200 + li));
      xfer = lu_valid && lu_ready;
      if (xfer) exp_q.push_back({lu_rd, lu_data});
      tick();
      if (xfer) li++;
      check($sformatf("full_c%0d_we", c), 32'(we), 32'd1);
      check($sformatf("full_c%0d_addr", c), 32'(writeaddr), 32'(20 + c));
      check($sformatf("full_c%0d_ready", c), 32'(lu_ready), 32'(c < 3));
      check($sformatf("full_c%0d_stall", c), 32'(stall_req), 32'(c >= 2));
    end
    for (int d = 0; d < 15; d++) begin
      drive(1'b0, 5'd0, 32'd0, li < 5, 5'(10 + li), 32'(32'h200 + li));
      xfer = lu_valid && lu_ready;
      if (xfer) exp_q.push_back({lu_rd, lu_data});
      tick();
      if (xfer) li++;
      if (we) begin
        if (exp_q.size() == 0) begin
          check("full_extra_write", 32'(writeaddr), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("full_order_addr", 32'(writeaddr), 32'(e[36:32]));
          check("full_order_data", writedata, e[31:0]);
        end
      end
    end
    check("full_all_sent", 32'(li), 32'd5);
    check("full_all_written", 32'(exp_q.size()), 32'd0);
    check("full_busy_clear", busy, 32'd0);
    check("full_stall_clear", 32'(stall_req), 32'd0);

    // starvation: one entry waits while the pipe ignores stall_req
    drive(1'b1, 5'd21, 32'h300, 1'b1, 5'd15, 32'h5A);
    tick();
    check("starve_c0_stall", 32'(stall_req), 32'd0);
    check("starve_c0_busy", busy, 32'h8000);
    for (int k = 1; k < 10; k++) begin
      drive(1'b1, 5'd22, 32'(32'h300 + k), 1'b0, 5'd0, 32'd0);
      tick();
      check($sformatf("starve_k%0d_stall", k), 32'(stall_req), 32'(k >= 7));
      check($sformatf("starve_k%0d_addr", k), 32'(writeaddr), 32'd22);
    end
    idle();
    tick();
    check("starve_pop_we", 32'(we), 32'd1);
    check("starve_pop_addr", 32'(writeaddr), 32'd15);
    check("starve_pop_data", writedata, 32'h5A);
    check("starve_pop_busy", busy, 32'd0);
    check("starve_pop_stall", 32'(stall_req), 32'd0);

    // reset mid-stream with 3 entries buffered
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd23, 32'(32'h400 + c), 1'b1, 5'(16 + c), 32'(32'h500 + c));
      tick();
    end
    check("mid_busy_before", busy, 32'h0007_0000);
    check("mid_stall_before", 32'(stall_req), 32'd1);
    check("mid_we_before", 32'(we), 32'd1);
    drive(1'b1, 5'd24, 32'h444, 1'b1, 5'd19, 32'h555);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_stall", 32'(stall_req), 32'd0);
    check("mid_rst_ready", 32'(lu_ready), 32'd1);
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("post_rst_c%0d_we", c), 32'(we), 32'd0);
      check($sformatf("post_rst_c%0d_busy", c), busy, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
